// File: rtl/prim_clock_sel_pkg.sv
// Shared types for the clock select sequencer: FSM state encoding and counter width.
package prim_clock_sel_pkg;

   localparam int unsigned SelCntW = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      GATE   = 2'b01,
      SETTLE = 2'b10,
      DONE   = 2'b11
   } sel_state_e;

endpackage

// File: rtl/prim_clock_sel_ctrl.sv
// Glitch-free select sequencer: gate en_o, flip sel_o after GateCycles, re-enable after SettleCycles.
// Switch latency GateCycles+SettleCycles; same-select 1 cycle; req_i ignored while busy (ready_o low).
module prim_clock_sel_ctrl
   import prim_clock_sel_pkg::*;
#(
   parameter int unsigned GateCycles   = 4,
   parameter int unsigned SettleCycles = 4,
   parameter logic        ResetSel     = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic req_i,
   input  logic sel_req_i,
   input  logic scanmode_i,
   output logic ready_o,
   output logic done_o,
   output logic en_o,
   output logic sel_o
);

   localparam logic [SelCntW-1:0] GateLoad   = SelCntW'(GateCycles - 1);
   localparam logic [SelCntW-1:0] SettleLoad = SelCntW'(SettleCycles - 1);

   if (GateCycles < 1 || GateCycles > 255) begin : g_bad_gate
      $error("GateCycles out of range 1..255");
   end
   if (SettleCycles < 1 || SettleCycles > 255) begin : g_bad_settle
      $error("SettleCycles out of range 1..255");
   end

   sel_state_e         state_q;
   logic [SelCntW-1:0] cnt_q;
   logic               tgt_q;
   logic               sel_q;
   logic               en_q;
   logic               done_q;

   assign ready_o = (state_q == IDLE) && !scanmode_i;
   assign en_o    = en_q | scanmode_i;
   assign sel_o   = sel_q;
   assign done_o  = done_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tgt_q   <= ResetSel;
         sel_q   <= ResetSel;
         en_q    <= 1'b1;
         done_q  <= 1'b0;
      end else if (scanmode_i) begin
         // Abort: select stays wherever the sequence left it, no completion pulse.
         state_q <= IDLE;
         cnt_q   <= '0;
         en_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_i) begin
                  if (sel_req_i != sel_q) begin
                     tgt_q   <= sel_req_i;
                     en_q    <= 1'b0;
                     cnt_q   <= GateLoad;
                     state_q <= GATE;
                  end else begin
                     state_q <= DONE;
                  end
               end
            end
            GATE: begin
               if (cnt_q == '0) begin
                  sel_q   <= tgt_q;
                  cnt_q   <= SettleLoad;
                  state_q <= SETTLE;
               end else begin
                  cnt_q <= cnt_q - SelCntW'(1);
               end
            end
            SETTLE: begin
               if (cnt_q == '0) begin
                  en_q    <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q - SelCntW'(1);
               end
            end
            DONE: begin
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
